// File: rtl/pixel_memory_responder.sv
// pixel_memory_responder
//   Responder for the pixel-stage memory interface. Accepts one request per
//   pause-low window from the active stage, runs it against the external
//   frame memory over a req/ack handshake and releases pause for one cycle
//   per completed transaction. An optional last-read cache lets a repeated
//   read of the same address skip the memory.
//
// Ports
//   clk_div_by_two  block clock (pixel-stage domain)
//   reset           synchronous, active-high
//   address/wren/data_write  stage request (sampled only in CAPTURE)
//   data_read       read result, valid while pause=0
//   pause           stage hold, low one cycle per completed transaction
//   mem_addr/mem_wdata/mem_we/mem_req  frame-memory request, held until ack
//   mem_ack/mem_rdata                  frame-memory completion
//   timeout_error   sticky timeout flag
//   txn_count       completed transaction count (wraps)
module pixel_memory_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter bit          CACHE_LAST     = 1'b1
) (
    input  logic        clk_div_by_two,
    input  logic        reset,
    input  logic [17:0] address,
    input  logic        wren,
    input  logic [31:0] data_write,
    output logic [31:0] data_read,
    output logic        pause,
    output logic [17:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        timeout_error,
    output logic [31:0] txn_count
);

    localparam int unsigned AW = 18;
    localparam int unsigned DW = 32;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_CAPTURE = 2'd0,
        S_WAIT    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    // State and registered outputs
    state_t          r_state;
    logic            r_pause;
    logic [DW-1:0]   r_data_read;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic            r_timeout_error;
    logic [DW-1:0]   r_txn_count;
    logic [TW-1:0]   r_tmo_cnt;
    logic            r_cache_valid;
    logic [AW-1:0]   r_cache_addr;
    logic [DW-1:0]   r_cache_data;

    // Next-state values
    state_t          w_state;
    logic            w_pause;
    logic [DW-1:0]   w_data_read;
    logic            w_mem_req;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_addr;
    logic [DW-1:0]   w_mem_wdata;
    logic            w_timeout_error;
    logic [DW-1:0]   w_txn_count;
    logic [TW-1:0]   w_tmo_cnt;
    logic            w_cache_valid;
    logic [AW-1:0]   w_cache_addr;
    logic [DW-1:0]   w_cache_data;

    logic            w_cache_hit;
    logic            w_tmo_last;

    // A read of the last cached address can be answered without memory
    assign w_cache_hit = CACHE_LAST && !wren && r_cache_valid && (address == r_cache_addr);
    assign w_tmo_last  = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Next-state and output logic
    always_comb begin
        w_state         = r_state;
        w_pause         = r_pause;
        w_data_read     = r_data_read;
        w_mem_req       = r_mem_req;
        w_mem_we        = r_mem_we;
        w_mem_addr      = r_mem_addr;
        w_mem_wdata     = r_mem_wdata;
        w_timeout_error = r_timeout_error;
        w_txn_count     = r_txn_count;
        w_tmo_cnt       = r_tmo_cnt;
        w_cache_valid   = r_cache_valid;
        w_cache_addr    = r_cache_addr;
        w_cache_data    = r_cache_data;

        case (r_state)
            S_CAPTURE: begin
                w_mem_addr  = address;
                w_mem_we    = wren;
                w_mem_wdata = data_write;
                if (w_cache_hit) begin
                    w_data_read = r_cache_data;
                    w_pause     = 1'b0;
                    w_state     = S_RELEASE;
                end else begin
                    w_mem_req = 1'b1;
                    w_tmo_cnt = '0;
                    w_state   = S_WAIT;
                end
            end

            S_WAIT: begin
                if (mem_ack) begin
                    w_mem_req = 1'b0;
                    w_mem_we  = 1'b0;
                    w_pause   = 1'b0;
                    w_state   = S_RELEASE;
                    if (!r_mem_we) begin
                        w_data_read   = mem_rdata;
                        w_cache_valid = 1'b1;
                        w_cache_addr  = r_mem_addr;
                        w_cache_data  = mem_rdata;
                    end else if (r_mem_addr == r_cache_addr) begin
                        // keep the cached copy coherent with the write
                        w_cache_data = r_mem_wdata;
                    end
                end else if (w_tmo_last) begin
                    w_mem_req       = 1'b0;
                    w_mem_we        = 1'b0;
                    w_timeout_error = 1'b1;
                    w_cache_valid   = 1'b0;
                    w_pause         = 1'b0;
                    w_state         = S_RELEASE;
                    if (!r_mem_we) begin
                        w_data_read = '0;
                    end
                end else begin
                    w_tmo_cnt = r_tmo_cnt + TW'(1);
                end
            end

            S_RELEASE: begin
                w_pause     = 1'b1;
                w_txn_count = r_txn_count + DW'(1);
                w_state     = S_CAPTURE;
            end

            default: begin
                w_pause   = 1'b1;
                w_mem_req = 1'b0;
                w_state   = S_CAPTURE;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk_div_by_two) begin
        if (reset) begin
            r_state         <= S_CAPTURE;
            r_pause         <= 1'b1;
            r_data_read     <= '0;
            r_mem_req       <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_timeout_error <= 1'b0;
            r_txn_count     <= '0;
            r_tmo_cnt       <= '0;
            r_cache_valid   <= 1'b0;
            r_cache_addr    <= '0;
            r_cache_data    <= '0;
        end else begin
            r_state         <= w_state;
            r_pause         <= w_pause;
            r_data_read     <= w_data_read;
            r_mem_req       <= w_mem_req;
            r_mem_we        <= w_mem_we;
            r_mem_addr      <= w_mem_addr;
            r_mem_wdata     <= w_mem_wdata;
            r_timeout_error <= w_timeout_error;
            r_txn_count     <= w_txn_count;
            r_tmo_cnt       <= w_tmo_cnt;
            r_cache_valid   <= w_cache_valid;
            r_cache_addr    <= w_cache_addr;
            r_cache_data    <= w_cache_data;
        end
    end

    assign data_read     = r_data_read;
    assign pause         = r_pause;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign mem_we        = r_mem_we;
    assign mem_req       = r_mem_req;
    assign timeout_error = r_timeout_error;
    assign txn_count     = r_txn_count;

endmodule

// File: tb/tb_pixel_memory_responder.sv
// tb_pixel_memory_responder
//   Acts as both the pixel stage and the frame memory around
//   pixel_memory_responder. A transaction-level model (memory contents,
//   last-read cache, counters) predicts latency, data_read and flags.
module tb_pixel_memory_responder;

    localparam int unsigned TMO = 64;

    logic        clk_div_by_two = 1'b0;
    logic        reset;
    logic [17:0] address;
    logic        wren;
    logic [31:0] data_write;
    logic [31:0] data_read;
    logic        pause;
    logic [17:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        timeout_error;
    logic [31:0] txn_count;

    pixel_memory_responder #(.TIMEOUT_CYCLES(TMO), .CACHE_LAST(1'b1)) dut (
        .clk_div_by_two (clk_div_by_two),
        .reset          (reset),
        .address        (address),
        .wren           (wren),
        .data_write     (data_write),
        .data_read      (data_read),
        .pause          (pause),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_we         (mem_we),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .timeout_error  (timeout_error),
        .txn_count      (txn_count)
    );

    always #5 clk_div_by_two = ~clk_div_by_two;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state
    logic [31:0] mem_model [int];
    logic        m_cache_v;
    logic [17:0] m_cache_a;
    logic [31:0] m_cache_d;
    logic [31:0] m_dr;
    logic [31:0] m_txn;
    logic        m_tmo;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_get(input logic [17:0] a);
        if (!mem_model.exists(int'(a))) mem_model[int'(a)] = $urandom;
        return mem_model[int'(a)];
    endfunction

    task automatic model_reset();
        m_cache_v = 1'b0;
        m_cache_a = '0;
        m_cache_d = '0;
        m_dr      = '0;
        m_txn     = '0;
        m_tmo     = 1'b0;
    endtask

    // One stage transaction. Called with the DUT in CAPTURE, #1 after an edge.
    // d = WAIT cycles before ack (ack in WAIT cycle d); d >= TMO means never ack.
    task automatic do_txn(input logic [17:0] a, input logic we, input logic [31:0] wd,
                          input int unsigned d, input bit spur_cap);
        bit          hit;
        bit          tmo;
        int unsigned n_wait;
        int unsigned low_at;
        logic [31:0] exp_dr;
        logic [31:0] old_txn;

        hit     = !we && m_cache_v && (a == m_cache_a);
        tmo     = !hit && (d >= TMO);
        n_wait  = hit ? 0 : (tmo ? TMO : d + 1);
        low_at  = n_wait + 1;
        old_txn = m_txn;

        // predicted outcome
        if (hit)           exp_dr = m_cache_d;
        else if (we)       exp_dr = m_dr;
        else if (tmo)      exp_dr = 32'h0;
        else               exp_dr = mem_get(a);

        address    = a;
        wren       = we;
        data_write = wd;
        mem_ack    = spur_cap;
        mem_rdata  = $urandom;

        for (int unsigned c = 1; c <= low_at + 1; c++) begin
            @(posedge clk_div_by_two);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            check_eq("pause", 32'(pause), (c == low_at) ? 32'h0 : 32'h1);
            check_eq("mem_req", 32'(mem_req), (c <= n_wait) ? 32'h1 : 32'h0);
            if (c <= n_wait) begin
                check_eq("mem_addr", 32'(mem_addr), 32'(a));
                check_eq("mem_we", 32'(mem_we), 32'(we));
                check_eq("mem_wdata", mem_wdata, wd);
                if (!tmo && (c - 1 == d)) begin
                    mem_ack = 1'b1;
                    if (we) mem_model[int'(a)] = wd;
                    else    mem_rdata = mem_get(a);
                end
            end
            if (c == low_at) begin
                check_eq("data_read", data_read, exp_dr);
                check_eq("txn_hold", txn_count, old_txn);
                if ($urandom_range(0, 3) == 0) mem_ack = 1'b1;
            end
            // stage churns its request lines outside CAPTURE
            if (c <= low_at) begin
                address    = 18'($urandom);
                wren       = 1'($urandom);
                data_write = $urandom;
            end
        end

        // model update
        m_txn = old_txn + 32'd1;
        m_dr  = exp_dr;
        if (tmo) begin
            m_tmo     = 1'b1;
            m_cache_v = 1'b0;
        end else if (!hit && !we) begin
            m_cache_v = 1'b1;
            m_cache_a = a;
            m_cache_d = exp_dr;
        end else if (we && m_cache_v && (a == m_cache_a)) begin
            m_cache_d = wd;
        end
        check_eq("txn_count", txn_count, m_txn);
        check_eq("timeout_error", 32'(timeout_error), 32'(m_tmo));
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_pause"}, 32'(pause), 32'h1);
        check_eq({tag, "_mem_req"}, 32'(mem_req), 32'h0);
        check_eq({tag, "_mem_we"}, 32'(mem_we), 32'h0);
        check_eq({tag, "_data_read"}, data_read, 32'h0);
        check_eq({tag, "_txn"}, txn_count, 32'h0);
        check_eq({tag, "_tmo"}, 32'(timeout_error), 32'h0);
    endtask

    initial begin
        reset      = 1'b1;
        address    = '0;
        wren       = 1'b0;
        data_write = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        model_reset();

        repeat (2) @(posedge clk_div_by_two);
        #1;
        check_reset_state("rst");
        check_eq("rst_mem_addr", 32'(mem_addr), 32'h0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;

        // directed cases
        mem_model[2240] = 32'h0000_0001;
        do_txn(18'd2240, 1'b0, 32'h0, 0, 1'b0);
        do_txn(18'd2241, 1'b1, 32'h0000_0001, 4, 1'b0);
        mem_model[100] = 32'h0000_000A;
        do_txn(18'd100, 1'b0, 32'h0, 0, 1'b0);
        do_txn(18'd100, 1'b0, 32'h0, 0, 1'b0);
        do_txn(18'd100, 1'b1, 32'h0000_000B, 1, 1'b0);
        do_txn(18'd100, 1'b0, 32'h0, 0, 1'b0);
        do_txn(18'd300, 1'b0, 32'h0, 1000, 1'b0);
        do_txn(18'd300, 1'b0, 32'h0, 2, 1'b0);
        do_txn(18'd301, 1'b1, 32'h1234_5678, 1000, 1'b0);
        do_txn(18'd300, 1'b0, 32'h0, TMO - 1, 1'b0);

        // reset in the middle of WAIT
        address = 18'd500;
        wren    = 1'b0;
        @(posedge clk_div_by_two);
        #1;
        check_eq("midrst_req_before", 32'(mem_req), 32'h1);
        @(posedge clk_div_by_two);
        #1;
        reset = 1'b1;
        @(posedge clk_div_by_two);
        #1;
        check_reset_state("midrst");
        model_reset();
        reset = 1'b0;
        // late ack lands in CAPTURE right after reset
        do_txn(18'd500, 1'b0, 32'h0, 0, 1'b1);

        // randomized traffic over a small address pool
        for (int i = 0; i < 150; i++) begin
            logic [17:0]  a;
            logic         we;
            int unsigned  d;
            case ($urandom_range(0, 3))
                0:       a = m_cache_a;
                1:       a = 18'd100 + 18'($urandom_range(0, 3));
                2:       a = 18'd2240 + 18'($urandom_range(0, 1));
                default: a = 18'($urandom);
            endcase
            we = ($urandom_range(0, 2) == 0);
            d  = ($urandom_range(0, 19) == 0) ? 200 : $urandom_range(0, 6);
            do_txn(a, we, $urandom, d, ($urandom_range(0, 4) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_memory_responder.md
Name: pixel_memory_responder

Overview:
- Responder side of the pixel-stage memory interface. A processing stage such as the X/Y filling passes drives address/wren/data_write and consumes data_read, and it advances only while pause is low.
- This block accepts exactly one request per pause-low window and performs it on the external frame memory through a req/ack handshake. It returns read data on data_read and releases pause for exactly one cycle per completed transaction.
- It sits between the active stage (via the stage mux) and the 18-bit-address, 32-bit-word frame memory.

Parameters:
- TIMEOUT_CYCLES, 64: maximum WAIT cycles before a forced completion.
- CACHE_LAST, 1: when 1, enables last-read short-circuit (repeat read of same address skips memory).

Ports:
- clk_div_by_two  input  1  block clock, same domain as the pixel stages.
- reset  input  1  synchronous, active-high reset.
- address  input  18  request address from the stage.
- wren  input  1  1 = write request, 0 = read request.
- data_write  input  32  write data.
- data_read  output  32  read result, valid while pause=0.
- pause  output  1  stage hold; low exactly one cycle per completed transaction.
- mem_addr  output  18  memory address.
- mem_wdata  output  32  memory write data.
- mem_we  output  1  memory write enable, qualified by mem_req.
- mem_req  output  1  memory request, held until ack.
- mem_ack  input  1  one-cycle completion pulse from memory.
- mem_rdata  input  32  read data, valid in the mem_ack cycle.
- timeout_error  output  1  sticky; set on any timeout.
- txn_count  output  32  completed transactions (wraps at 2^32).

Behaviour:
- Reset (synchronous, active-high): pause=1, data_read=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, timeout_error=0, txn_count=0, cache invalid, state=CAPTURE. Reset mid-transaction abandons it: mem_req drops the next cycle and no data_read update occurs.
- All outputs are registered.
- States: CAPTURE, WAIT, RELEASE.
- CAPTURE (pause=1): latch address/wren/data_write into mem_addr/mem_we/mem_wdata.
  - If CACHE_LAST=1, wren=0, cache valid and address==cached address: do not touch memory; data_read<=cached data; pause<=0; go RELEASE.
  - Otherwise: mem_req<=1; clear timeout counter; go WAIT.
- WAIT (mem_req=1): each cycle, sample mem_ack.
  - On ack: mem_req<=0, mem_we<=0, pause<=0, go RELEASE.
  - On a read ack: data_read<=mem_rdata, and the cache is loaded with (mem_addr, mem_rdata).
  - On a write ack: data_read unchanged. If the written address equals the cached address, cached data<=mem_wdata.
  - Timeout: when the counter reaches TIMEOUT_CYCLES-1 with no ack: mem_req<=0, timeout_error<=1, data_read<=0 for reads (unchanged for writes), cache invalidated, pause<=0, go RELEASE.
- RELEASE (pause=0, one cycle): the stage consumes data_read and presents its next request on this edge. Responder sets pause<=1, increments txn_count, and goes to CAPTURE.
- Latency: memory path is 3 cycles minimum per transaction (ack in first WAIT cycle), plus 1 per extra WAIT cycle. Cache hit is 2 cycles.
- mem_ack while mem_req=0 is ignored.
- mem_addr, mem_we and mem_wdata are stable for the whole time mem_req=1.
- pause is never low for two consecutive cycles.
- Request inputs are sampled only in CAPTURE; changes at any other time are ignored.

Test Plan:
- Read, memory acks on first WAIT cycle with mem_rdata=32'h0000_0001, address=2240 -> mem_req high 1 cycle with mem_addr=2240, mem_we=0; data_read=1 and pause=0 for exactly one cycle, 3 cycles after capture; txn_count=1.
- Write address=2241, data_write=1, ack after 5 WAIT cycles -> mem_we=1, mem_wdata=1 held stable for all 5 cycles; data_read unchanged; pause low one cycle; txn_count increments.
- CACHE_LAST=1: read 100 returns 32'hA, then read 100 again -> second has no mem_req, data_read=32'hA with pause low 2 cycles after capture. Then write 100=32'hB, read 100 -> 32'hB with no mem_req.
- No ack for TIMEOUT_CYCLES=64 on a read -> mem_req drops after 64 WAIT cycles, timeout_error=1 (stays 1), data_read=0, pause low one cycle. A later normal read completes correctly.
- Reset asserted during WAIT -> next cycle mem_req=0, pause=1, txn_count=0, timeout_error=0. A late mem_ack arriving after reset is ignored.
- Stage toggles address while pause=1 outside CAPTURE, and a spurious mem_ack pulses in RELEASE -> only the CAPTURE-sampled address reaches mem_addr; no extra transactions counted.
